// File: rtl/stack_exec_unit.sv
// Stack-machine instruction sequencer: turns PUSH/POP/ALU instructions into Stack
// Push/Pop command sequences, tracking occupancy so illegal instructions never reach the stack.
module stack_exec_unit #(
  parameter int WORD_RANGE = 8,
  parameter int WORD_COUNT = 64
) (
  input  logic                              Clk,
  input  logic                              RstN,
  input  logic                              Instr_valid,
  output logic                              Instr_ready,
  input  logic [2:0]                        Opcode,
  input  logic [WORD_RANGE-1:0]             Imm,
  output logic                              St_Enable,
  output logic                              St_Push,
  output logic                              St_Pop,
  output logic [WORD_RANGE-1:0]             St_Data_in,
  input  logic [WORD_RANGE-1:0]             St_Data_out,
  output logic [WORD_RANGE-1:0]             Result,
  output logic                              Result_valid,
  output logic                              Carry,
  output logic                              Error,
  output logic [$clog2(WORD_COUNT+1)-1:0]   Depth
);

  localparam int DW = $clog2(WORD_COUNT + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(WORD_COUNT);

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP1, S_POP2, S_OUT, S_WB} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [WORD_RANGE-1:0] imm_q, imm_d;
  logic [WORD_RANGE-1:0] a_q, a_d;
  logic [WORD_RANGE-1:0] result_q, result_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic                  error_q, error_d;
  logic                  carry_q, carry_d;
  logic                  ready_q, ready_d;
  logic                  st_en_q, st_en_d;
  logic                  st_push_q, st_push_d;
  logic                  st_pop_q, st_pop_d;
  logic                  rv_q, rv_d;
  logic [WORD_RANGE:0]   alu_ext;

  // ALU: B (arriving on St_Data_out in WB) op A (captured at end of POP2)
  always_comb begin
    alu_ext = '0;
    case (op_q)
      OP_ADD:  alu_ext = {1'b0, St_Data_out} + {1'b0, a_q};
      OP_SUB:  alu_ext = {1'b0, St_Data_out} - {1'b0, a_q};
      OP_AND:  alu_ext = {1'b0, St_Data_out & a_q};
      OP_OR:   alu_ext = {1'b0, St_Data_out | a_q};
      OP_XOR:  alu_ext = {1'b0, St_Data_out ^ a_q};
      default: alu_ext = '0;
    endcase
  end

  // Next-state, bookkeeping and next-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    a_d      = a_q;
    result_d = result_q;
    depth_d  = depth_q;
    error_d  = error_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (Instr_valid) begin
          op_d  = Opcode;
          imm_d = Imm;
          case (Opcode)
            OP_PUSH: begin
              if (depth_q == DEPTH_FULL) error_d = 1'b1;
              else                       state_d = S_PUSH;
            end
            OP_POP: begin
              if (depth_q == '0) error_d = 1'b1;
              else               state_d = S_POP1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              if (depth_q < DW'(2)) error_d = 1'b1;
              else                  state_d = S_POP1;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: begin
        depth_d = depth_q + DW'(1);
        state_d = S_IDLE;
      end
      S_POP1: begin
        depth_d = depth_q - DW'(1);
        state_d = (op_q == OP_POP) ? S_OUT : S_POP2;
      end
      S_POP2: begin
        depth_d = depth_q - DW'(1);
        a_d     = St_Data_out;
        state_d = S_WB;
      end
      S_OUT: begin
        result_d = St_Data_out;
        state_d  = S_IDLE;
      end
      S_WB: begin
        depth_d  = depth_q + DW'(1);
        result_d = alu_ext[WORD_RANGE-1:0];
        if (op_q == OP_ADD || op_q == OP_SUB) carry_d = alu_ext[WORD_RANGE];
        else                                  carry_d = carry_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d   = (state_d == S_IDLE);
    st_push_d = (state_d == S_PUSH) || (state_d == S_WB);
    st_pop_d  = (state_d == S_POP1) || (state_d == S_POP2);
    st_en_d   = st_push_d || st_pop_d;
    rv_d      = (state_d == S_OUT) || (state_d == S_WB);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (RstN) begin
      state_q   <= S_IDLE;
      op_q      <= 3'b000;
      imm_q     <= '0;
      a_q       <= '0;
      result_q  <= '0;
      depth_q   <= '0;
      error_q   <= 1'b0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b1;
      st_en_q   <= 1'b0;
      st_push_q <= 1'b0;
      st_pop_q  <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      result_q  <= result_d;
      depth_q   <= depth_d;
      error_q   <= error_d;
      carry_q   <= carry_d;
      ready_q   <= ready_d;
      st_en_q   <= st_en_d;
      st_push_q <= st_push_d;
      st_pop_q  <= st_pop_d;
      rv_q      <= rv_d;
    end
  end

  // Stack output is only valid in OUT/WB itself, so those words bypass the result register
  always_comb begin
    if (rv_q) Result = (state_q == S_OUT) ? St_Data_out : alu_ext[WORD_RANGE-1:0];
    else      Result = result_q;
    if (st_push_q) St_Data_in = (state_q == S_WB) ? alu_ext[WORD_RANGE-1:0] : imm_q;
    else           St_Data_in = '0;
  end

  assign Instr_ready  = ready_q;
  assign St_Enable    = st_en_q;
  assign St_Push      = st_push_q;
  assign St_Pop       = st_pop_q;
  assign Result_valid = rv_q;
  assign Carry        = carry_q;
  assign Error        = error_q;
  assign Depth        = depth_q;

endmodule

// File: tb/tb_stack_exec_unit.sv
// Scoreboard bench for stack_exec_unit with a behavioural Stack model attached.
module tb_stack_exec_unit;
  localparam int WR = 8;
  localparam int WC = 4;
  localparam int DW = $clog2(WC + 1);

  logic          Clk = 1'b0;
  logic          RstN = 1'b0;
  logic          Instr_valid = 1'b0;
  logic          Instr_ready;
  logic [2:0]    Opcode = 3'b000;
  logic [WR-1:0] Imm = '0;
  logic          St_Enable, St_Push, St_Pop;
  logic [WR-1:0] St_Data_in;
  logic [WR-1:0] St_Data_out;
  logic [WR-1:0] Result;
  logic          Result_valid, Carry, Error;
  logic [DW-1:0] Depth;

  stack_exec_unit #(.WORD_RANGE(WR), .WORD_COUNT(WC)) dut (
    .Clk(Clk), .RstN(RstN), .Instr_valid(Instr_valid), .Instr_ready(Instr_ready),
    .Opcode(Opcode), .Imm(Imm), .St_Enable(St_Enable), .St_Push(St_Push), .St_Pop(St_Pop),
    .St_Data_in(St_Data_in), .St_Data_out(St_Data_out), .Result(Result),
    .Result_valid(Result_valid), .Carry(Carry), .Error(Error), .Depth(Depth)
  );

  always #5 Clk = ~Clk;

  // Behavioural Stack: registered output, valid the cycle after a Pop
  logic [WR-1:0] mem [0:7];
  int sp = 0;
  logic [WR-1:0] sdo = '0;
  assign St_Data_out = sdo;
  always @(posedge Clk) begin
    if (RstN) begin
      sp  <= 0;
      sdo <= '0;
    end else if (St_Enable && St_Push && sp < 8) begin
      mem[sp] <= St_Data_in;
      sp      <= sp + 1;
    end else if (St_Enable && St_Pop && sp > 0) begin
      sdo <= mem[sp-1];
      sp  <= sp - 1;
    end
  end

  int cyc = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (St_Enable && St_Push) push_cnt <= push_cnt + 1;
    if (St_Enable && St_Pop)  pop_cnt  <= pop_cnt + 1;
  end

  typedef struct { logic [WR-1:0] data; int cycle; } exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares each Result_valid strobe against the scoreboard head
  always @(negedge Clk) begin
    exp_t e;
    if (St_Push && St_Pop) chk("push_and_pop_together", 32'd1, 32'd0);
    if (Result_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result_data", {24'd0, Result}, {24'd0, e.data});
        chk("result_cycle", cyc, e.cycle);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge Clk);
    while (!Instr_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!Instr_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one instruction; exp_lat 0 = no result expected
  task automatic issue(input logic [2:0] op, input logic [WR-1:0] imm,
                       input int exp_lat, input logic [WR-1:0] exp_val);
    exp_t e;
    wait_ready();
    if (exp_lat > 0) begin
      e.data  = exp_val;
      e.cycle = cyc + exp_lat;
      exp_q.push_back(e);
    end
    Opcode = op;
    Imm = imm;
    Instr_valid = 1'b1;
    @(posedge Clk);
    #1;
    Instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    RstN = 1'b1;
    repeat (2) @(negedge Clk);
    RstN = 1'b0;
  endtask

  initial begin
    int pc, uc;
    do_reset();
    chk("rst_depth", Depth, 0);
    chk("rst_ready", Instr_ready, 1);
    chk("rst_error", Error, 0);
    chk("rst_carry", Carry, 0);
    chk("rst_st_enable", {St_Enable, St_Push, St_Pop}, 0);
    chk("rst_result", {Result_valid, Result}, 0);

    issue(3'b001, 8'h05, 0, 8'h00);
    issue(3'b001, 8'h03, 0, 8'h00);
    issue(3'b100, 8'h00, 3, 8'h02);
    wait_ready();
    chk("sub1_carry", Carry, 0);
    chk("sub1_depth", Depth, 1);
    issue(3'b010, 8'h00, 2, 8'h02);
    wait_ready();
    chk("pop1_depth", Depth, 0);

    issue(3'b001, 8'hFF, 0, 8'h00);
    issue(3'b001, 8'h01, 0, 8'h00);
    issue(3'b011, 8'h00, 3, 8'h00);
    wait_ready();
    chk("add_carry", Carry, 1);
    issue(3'b001, 8'h00, 0, 8'h00);
    issue(3'b100, 8'h00, 3, 8'h00);
    wait_ready();
    chk("sub0_carry", Carry, 0);
    issue(3'b001, 8'h01, 0, 8'h00);
    issue(3'b100, 8'h00, 3, 8'hFF);
    wait_ready();
    chk("borrow_carry", Carry, 1);
    chk("borrow_depth", Depth, 1);
    issue(3'b010, 8'h00, 2, 8'hFF);
    wait_ready();
    chk("empty_depth", Depth, 0);

    // POP on empty stack
    pc = pop_cnt;
    issue(3'b010, 8'h00, 0, 8'h00);
    chk("pop_empty_error", Error, 1);
    chk("pop_empty_ready", Instr_ready, 1);
    chk("pop_empty_depth", Depth, 0);
    @(negedge Clk);
    chk("pop_empty_no_pop", pop_cnt, pc);

    // ADD with a single entry, after clearing the sticky error
    do_reset();
    chk("rst2_error", Error, 0);
    issue(3'b001, 8'h07, 0, 8'h00);
    wait_ready();
    pc = pop_cnt;
    issue(3'b011, 8'h00, 0, 8'h00);
    chk("add_short_error", Error, 1);
    chk("add_short_depth", Depth, 1);
    @(negedge Clk);
    chk("add_short_no_pop", pop_cnt, pc);

    // Overflow
    do_reset();
    for (int i = 1; i <= 4; i++) issue(3'b001, 8'(i), 0, 8'h00);
    wait_ready();
    chk("full_depth", Depth, 4);
    chk("full_no_error", Error, 0);
    uc = push_cnt;
    issue(3'b001, 8'h09, 0, 8'h00);
    chk("overflow_error", Error, 1);
    chk("overflow_ready", Instr_ready, 1);
    @(negedge Clk);
    chk("overflow_no_push", push_cnt, uc);
    chk("overflow_depth", Depth, 4);
    issue(3'b010, 8'h00, 2, 8'h04);
    wait_ready();
    chk("after_pop_depth", Depth, 3);

    // Reset asserted during POP2 of an ADD
    do_reset();
    issue(3'b001, 8'h11, 0, 8'h00);
    issue(3'b001, 8'h22, 0, 8'h00);
    issue(3'b011, 8'h00, 0, 8'h00);
    @(negedge Clk);
    chk("midrst_in_pop", St_Pop, 1);
    @(negedge Clk);
    chk("midrst_in_pop2", St_Pop, 1);
    RstN = 1'b1;
    @(negedge Clk);
    RstN = 1'b0;
    chk("midrst_depth", Depth, 0);
    chk("midrst_ready", Instr_ready, 1);
    chk("midrst_no_valid", Result_valid, 0);
    repeat (3) @(negedge Clk);
    issue(3'b010, 8'h00, 0, 8'h00);
    chk("midrst_pop_error", Error, 1);

    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
